// File: rtl/mano_io_pkg.sv
// =============================================================================
// Module      : mano_io_pkg
// Description : Shared types and constants for the Mano machine serial output.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package mano_io_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    typedef enum logic [2:0] {
        UART_IDLE     = 3'd0,
        UART_START    = 3'd1,
        UART_DATA     = 3'd2,
        UART_PARITY   = 3'd3,
        UART_STOP     = 3'd4,
        UART_DONE     = 3'd5,
        UART_WAIT_FGO = 3'd6
    } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// =============================================================================
// Module      : uart_baud_tick
// Description : Bit-period counter; one-cycle tick every CLKS_PER_BIT cycles.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_count;
    logic               w_last;

    assign w_last = (r_count == c_LAST);
    assign o_tick = w_last && !i_clear;

    always_ff @(posedge clk) begin
        if (rst || i_clear || w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_out_dev.sv
// =============================================================================
// Module      : uart_out_dev
// Description : Mano OUTR/FGO serial output device; sends each character as a
//               UART frame (8N1, or 8E1 when UART_PARITY_EN is defined).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module uart_out_dev
    import mano_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       io_clock,
    input  logic       io_reset,
    input  logic [7:0] io_outr,
    input  logic       io_fgo,
    output logic       io_fgoset,
    output logic       io_txd,
    output logic       io_busy
);

    localparam logic [2:0] c_ST_IDLE     = UART_IDLE;
    localparam logic [2:0] c_ST_START    = UART_START;
    localparam logic [2:0] c_ST_DATA     = UART_DATA;
`ifdef UART_PARITY_EN
    localparam logic [2:0] c_ST_PARITY   = UART_PARITY;
`endif
    localparam logic [2:0] c_ST_STOP     = UART_STOP;
    localparam logic [2:0] c_ST_DONE     = UART_DONE;
    localparam logic [2:0] c_ST_WAIT_FGO = UART_WAIT_FGO;
    localparam logic [2:0] c_LAST_BIT    = 3'(UART_DATA_BITS - 1);

    logic [2:0] r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_txd;
    logic       r_fgoset;
    logic       r_busy;
`ifdef UART_PARITY_EN
    logic       r_parity;
`endif
    logic       w_clear;
    logic       w_tick;

    // The bit timer only runs while a frame is on the wire.
    assign w_clear = (r_state == c_ST_IDLE) || (r_state == c_ST_DONE) ||
                     (r_state == c_ST_WAIT_FGO);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (io_clock),
        .rst     (io_reset),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            r_state   <= c_ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_txd     <= 1'b1;
            r_fgoset  <= 1'b0;
            r_busy    <= 1'b0;
`ifdef UART_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            // Outputs follow the state one cycle later so they are all registered.
            r_fgoset <= (r_state == c_ST_DONE);
            r_busy   <= (r_state != c_ST_IDLE);
            case (r_state)
                c_ST_START:  r_txd <= 1'b0;
                c_ST_DATA:   r_txd <= r_shift[0];
`ifdef UART_PARITY_EN
                c_ST_PARITY: r_txd <= r_parity;
`endif
                default:     r_txd <= 1'b1;
            endcase

            case (r_state)
                c_ST_IDLE: begin
                    if (!io_fgo) begin
                        r_shift   <= io_outr;
                        r_bit_cnt <= '0;
`ifdef UART_PARITY_EN
                        r_parity  <= 1'b0;
`endif
                        r_state   <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (w_tick) begin
                        r_state <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_tick) begin
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
`ifdef UART_PARITY_EN
                        r_parity  <= r_parity ^ r_shift[0];
`endif
                        if (r_bit_cnt == c_LAST_BIT) begin
`ifdef UART_PARITY_EN
                            r_state <= c_ST_PARITY;
`else
                            r_state <= c_ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_PARITY_EN
                c_ST_PARITY: begin
                    if (w_tick) begin
                        r_state <= c_ST_STOP;
                    end
                end
`endif
                c_ST_STOP: begin
                    if (w_tick) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_WAIT_FGO;
                end
                c_ST_WAIT_FGO: begin
                    // A lingering FGO=0 must not start another frame.
                    if (io_fgo) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign io_txd    = r_txd;
    assign io_fgoset = r_fgoset;
    assign io_busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_out_dev.sv
// =============================================================================
// Module      : tb_uart_out_dev
// Description : Self-checking bench for uart_out_dev with CLKS_PER_BIT=4.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_uart_out_dev;

    localparam int N = 4;
`ifdef UART_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif

    logic       clk;
    logic       io_reset;
    logic [7:0] io_outr;
    logic       io_fgo;
    logic       io_fgoset;
    logic       io_txd;
    logic       io_busy;

    int errors = 0;
    int checks = 0;

    uart_out_dev #(
        .CLKS_PER_BIT (N)
    ) dut (
        .io_clock  (clk),
        .io_reset  (io_reset),
        .io_outr   (io_outr),
        .io_fgo    (io_fgo),
        .io_fgoset (io_fgoset),
        .io_txd    (io_txd),
        .io_busy   (io_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag, input logic busy_exp);
        chk({tag, "_txd"}, io_txd, 1'b1);
        chk({tag, "_fgoset"}, io_fgoset, 1'b0);
        chk({tag, "_busy"}, io_busy, busy_exp);
    endtask

    // Starts a frame at the next edge (edge 0) and checks every cycle up to the
    // fgoset pulse; optionally disturbs OUTR or resets at a given cycle.
    task automatic run_frame(input logic [7:0] b, input int chg_cycle,
                             input logic [7:0] chg_val, input int abort_at);
        logic q[$];
        q = {};
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(b[i]);
`ifdef UART_PARITY_EN
        q.push_back(^b);
`endif
        q.push_back(1'b1);

        io_outr = b;
        io_fgo  = 1'b0;
        step();
        chk("c0_txd", io_txd, 1'b1);
        chk("c0_busy", io_busy, 1'b0);
        for (int c = 1; c <= F * N + 1; c++) begin
            step();
            if (c <= F * N) chk("txd_bit", io_txd, q[(c - 1) / N]);
            else            chk("txd_after", io_txd, 1'b1);
            chk("fgoset", io_fgoset, (c == F * N + 1));
            chk("busy", io_busy, 1'b1);
            if (c == chg_cycle) io_outr = chg_val;
            if (c == abort_at) begin
                io_reset = 1'b1;
                step();
                chk_idle_outputs("abort", 1'b0);
                io_reset = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        logic [7:0] rb;

        io_reset = 1'b1;
        io_fgo   = 1'b1;
        io_outr  = 8'h00;

        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle_outputs("reset", 1'b0);
        end
        io_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle_outputs("post_reset", 1'b0);
        end

        // Basic character with processor feedback one cycle after the pulse.
        run_frame(8'h05, 0, 8'h00, 0);
        io_fgo = 1'b1;
        step();
        chk("enq_fgoset_clear", io_fgoset, 1'b0);
        chk("enq_busy_hold", io_busy, 1'b1);
        step();
        chk("enq_busy_fall", io_busy, 1'b0);

`ifdef UART_PARITY_EN
        run_frame(8'h07, 0, 8'h00, 0);
        io_fgo = 1'b1;
        step();
        step();
        chk("par_busy_fall", io_busy, 1'b0);
`endif

        // OUTR change during data bit 2 must not reach the line.
        run_frame(8'h3C, 3 * N + 2, 8'hFF, 0);
        io_fgo = 1'b1;
        step();
        step();
        chk("latch_busy_fall", io_busy, 1'b0);

        // Reset during data bit 3, then a fresh frame with FGO still low.
        run_frame(8'hA5, 4 * N + 2, 8'hA5, 4 * N + 2);
        run_frame(8'hA5, 0, 8'h00, 0);

        // FGO held low after the pulse: no second frame.
        for (int i = 0; i < 100; i++) begin
            step();
            chk_idle_outputs("hold_low", 1'b1);
        end
        io_fgo = 1'b1;
        step();
        step();
        chk("rearm_busy_fall", io_busy, 1'b0);

        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom);
            run_frame(rb, 0, 8'h00, 0);
            io_fgo = 1'b1;
            step();
            step();
            chk("rand_busy_fall", io_busy, 1'b0);
        end

        for (int i = 0; i < 20; i++) begin
            step();
            chk_idle_outputs("final_idle", 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_out_dev.md
# uart_out_dev

Serial output device for the Mano machine's character output port. It takes the place of the behavioural "slow output device" on the board build. When the processor clears FGO, the block latches OUTR and shifts it out as an 8N1 UART frame on `io_txd`. It then pulses `io_fgoset` for one cycle so the processor sees the device ready again. It sits directly downstream of the processor's OUTR/FGO pair and drives the same `io_fgoset` line the top level exposes.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: `io_clock` cycles per UART bit (100 MHz / 115200). Minimum 2.

Ports:
- `io_clock` in 1: system clock. One clock domain; all logic on the rising edge.
- `io_reset` in 1: reset, synchronous, active-high.
- `io_outr` in 8: processor output register (character to send).
- `io_fgo` in 1: processor output flag. 0 means a character is pending.
- `io_fgoset` out 1: one-cycle pulse that sets FGO when the character has been sent.
- `io_txd` out 1: UART serial line, idle high.
- `io_busy` out 1: high from character latch until return to IDLE.

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP, DONE, WAIT_FGO.
- IDLE:
  - If `io_fgo==0` is sampled, latch `io_outr` into the shift register, clear the bit counter, go to START.
- START:
  - `io_txd=0` for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - Shift out 8 bits, LSB first, each for CLKS_PER_BIT cycles.
  - After bit 7, go to PARITY if compiled in, otherwise to STOP.
- STOP:
  - `io_txd=1` for CLKS_PER_BIT cycles, then go to DONE.
- DONE:
  - `io_fgoset=1` for exactly this one cycle, then go to WAIT_FGO.
- WAIT_FGO:
  - Hold until `io_fgo==1` is sampled, then go to IDLE.
  - This prevents a stale FGO=0 from retriggering a frame.
- `io_outr` and `io_fgo` are ignored outside IDLE and WAIT_FGO.
- The latched byte is immune to OUTR changes mid-frame.
- Bit-period counter width is `$clog2(CLKS_PER_BIT)`.
  - It reloads to 0 on every bit boundary and never wraps past CLKS_PER_BIT-1.
- Reset values: `io_txd=1`, `io_fgoset=0`, `io_busy=0`, state IDLE, counters 0, shift register 0.
- Reset mid-frame:
  - Frame is aborted and `io_txd` returns to 1 at the next edge.
  - No `io_fgoset` pulse is issued.
  - After reset releases, a still-low FGO starts a fresh frame.

## Timing
- Edge 0: IDLE samples `io_fgo==0`.
- After edge 1: `io_txd` low and `io_busy` high.
- Bit k (start=0, data 1..8, stop=9) occupies cycles `1+k*N` to `k*N+N` after edge 0, where N=CLKS_PER_BIT.
- `io_fgoset` is high in the cycle after edge `1+10N`, i.e. 10N+1 cycles of latency. With parity: 11N+1.
- `io_busy` drops on the edge after WAIT_FGO samples `io_fgo==1`. With normal FGO feedback this is 2 cycles after the `io_fgoset` pulse.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `UART_PARITY_EN` defined:
  - PARITY state is inserted between DATA and STOP.
  - It transmits even parity (XOR of the 8 data bits) for N cycles.
  - Frame is 11 bits.
- Undefined:
  - PARITY state and the parity XOR are not compiled.
  - Frame is 10 bits (8N1).

## Structure
- Shared package `mano_io_pkg`:
  - state enum `uart_state_t`;
  - constants `UART_DATA_BITS=8`, `UART_STOP_BITS=1`.
- One sub-module, `uart_baud_tick`:
  - bit-period counter with synchronous clear;
  - outputs a one-cycle `tick` every CLKS_PER_BIT cycles;
  - held cleared in IDLE, DONE and WAIT_FGO.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: assert `io_reset` 3 cycles with `io_fgo=1` -> `io_txd=1`, `io_fgoset=0`, `io_busy=0` throughout and after.
- ENQ: `io_outr=8'h05`, `io_fgo` 1->0 at edge 0 -> `io_txd` sequence per 4-cycle bit: 0, 1,0,1,0,0,0,0,0, 1. Single `io_fgoset` pulse at cycle 41. Bench then drives `io_fgo=1` and `io_busy` falls 2 cycles later.
- Latch hold: start frame with `8'h3C`, change `io_outr` to `8'hFF` during data bit 2 -> transmitted bits remain 0,0,1,1,1,1,0,0.
- Reset mid-frame: assert `io_reset` during data bit 3 of `8'hA5` -> `io_txd=1` next cycle, no `io_fgoset`. With `io_fgo` still 0 after release, a full new `8'hA5` frame follows.
- No retrigger: after the `io_fgoset` pulse, hold `io_fgo=0` for 100 cycles -> no second frame and `io_busy` stays 1. Raise then lower `io_fgo` -> exactly one new frame.
- Parity (`UART_PARITY_EN`): `8'h07` -> parity bit 1 in cycles 37-40, stop bit cycles 41-44, `io_fgoset` at cycle 45.
